demux8_deser: RTL and testbench

- Receive-side counterpart of the 8-to-1 select mux. The mux drives lane I[Sel] onto one wire while Sel steps 0..7; this block takes that single bit stream and steers each bit back into lane Sel of an 8-bit word.
- It is a 1-to-8 demultiplexing deserializer: an internal lane counter, frame alignment on `start`, and a valid/ready output holding register.
- Sits between the serial link (mux output F) and the parallel consumer.

---
 rtl/demux8_deser_pkg.sv | 12 +
 rtl/demux8_deser_lane_counter.sv | 45 ++++
 rtl/demux8_deser.sv | 122 ++++++++++++
 tb/tb_demux8_deser.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux8_deser_pkg.sv
// Shared constants and state encoding for the 1-to-8 demultiplexing deserializer.
package demux8_deser_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/demux8_deser_lane_counter.sv
// Lane index counter: wraps LANES-1 -> 0, clear has priority over enable.
// A clear together with enable means lane 0 is being written this cycle,
// so the count lands on 1 rather than 0.
module lane_counter #(
  parameter int LANES = demux8_deser_pkg::LANES,
  parameter int SEL_W = demux8_deser_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [SEL_W-1:0] count,
  output logic             last
);

  import demux8_deser_pkg::*;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] count_reg;
  logic [SEL_W-1:0] count_next;

  // Next count: clear restarts the frame, enable advances one lane.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = enable ? SEL_W'(1) : '0;
    end else if (enable) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == LAST_IDX);

endmodule

// File: rtl/demux8_deser.sv
// 1-to-8 demultiplexing deserializer: steers each accepted serial bit into
// lane sel of a shadow word and hands completed words to a valid/ready
// holding register. Completed words that cannot be stored are dropped and
// flagged with a one-cycle overrun pulse.
module demux8_deser #(
  parameter int LANES = demux8_deser_pkg::LANES,
  parameter int SEL_W = demux8_deser_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             busy
);

  import demux8_deser_pkg::*;

  state_t           state_reg;
  state_t           state_next;

  logic [SEL_W-1:0] lane_idx;
  logic             lane_last;
  logic [SEL_W-1:0] lane_sel;

  logic             accept;
  logic             complete;
  logic             transfer;

  logic [LANES-1:0] lane_wr;
  logic [LANES-1:0] shadow_reg;
  logic [LANES-1:0] shadow_next;

  logic [LANES-1:0] dout_reg;
  logic [LANES-1:0] dout_next;
  logic             dout_valid_reg;
  logic             dout_valid_next;
  logic             overrun_reg;
  logic             overrun_next;

  // A bit is taken while collecting, or on the start cycle itself (lane 0).
  assign accept   = din_valid & (start | (state_reg == ST_COLLECT));
  // Start always writes lane 0, so it can never complete a word.
  assign complete = accept & ~start & lane_last;
  assign transfer = dout_valid_reg & dout_ready;
  assign lane_sel = start ? '0 : lane_idx;

  lane_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_lane_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (accept),
    .count  (lane_idx),
    .last   (lane_last)
  );

  // Per-lane write decode; start wipes the partial word before lane 0 lands.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [SEL_W-1:0] LANE_ID = SEL_W'(gi);
      assign lane_wr[gi]     = accept & (lane_sel == LANE_ID);
      assign shadow_next[gi] = lane_wr[gi] ? din :
                               (start ? 1'b0 : shadow_reg[gi]);
    end
  endgenerate

  // Next state and output holding register; shadow_next is the completed
  // word on a completion cycle because lane LANES-1 is already merged in.
  always_comb begin
    state_next      = state_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    overrun_next    = 1'b0;

    if (start) begin
      state_next = ST_COLLECT;
    end

    if (complete) begin
      if (!dout_valid_reg || dout_ready) begin
        dout_next       = shadow_next;
        dout_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (transfer) begin
      dout_valid_next = 1'b0;
    end
  end

  // State, shadow word and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      shadow_reg     <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shadow_reg     <= shadow_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign sel        = lane_idx;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg == ST_COLLECT);

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: directed scenarios followed by random traffic,
// all checked against a word-level reference model.
module tb_demux8_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       din;
  logic       din_valid;
  logic       dout_ready;
  logic [2:0] sel;
  logic [7:0] dout;
  logic       dout_valid;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit       m_collect;
  int       m_lane;
  bit [7:0] m_part;
  bit [7:0] m_held;
  bit       m_valid;
  bit       m_ovr;
  int       m_words;

  demux8_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, described in terms of frames and lanes.
  task automatic model_edge(input bit r, input bit s, input bit dv, input bit d, input bit rdy);
    bit       done;
    bit [7:0] word;
    done = 1'b0;
    word = '0;
    if (!r) begin
      m_collect = 1'b0;
      m_lane    = 0;
      m_part    = '0;
      m_held    = '0;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
      return;
    end
    if (s) begin
      m_collect = 1'b1;
      m_lane    = 0;
      m_part    = '0;
    end
    if (dv && m_collect) begin
      m_part[m_lane] = d;
      if (m_lane == 7) begin
        done = 1'b1;
        word = m_part;
      end
      m_lane = (m_lane + 1) % 8;
    end
    m_ovr = 1'b0;
    if (done) begin
      m_words++;
      if (!m_valid || rdy) begin
        m_held  = word;
        m_valid = 1'b1;
        $display("word %0d: %02h stored", m_words, word);
      end else begin
        m_ovr = 1'b1;
        $display("word %0d: %02h dropped (held %02h)", m_words, word, m_held);
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare everything.
  task automatic step(input bit r, input bit s, input bit dv, input bit d, input bit rdy);
    rst_n      = r;
    start      = s;
    din_valid  = dv;
    din        = d;
    dout_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(r, s, dv, d, rdy);
    check("sel",        sel,        32'(m_lane));
    check("busy",       busy,       32'(m_collect));
    check("dout",       dout,       32'(m_held));
    check("dout_valid", dout_valid, 32'(m_valid));
    check("overrun",    overrun,    32'(m_ovr));
  endtask

  task automatic send_bit(input bit d, input bit rdy);
    step(1'b1, 1'b0, 1'b1, d, rdy);
  endtask

  task automatic send_word(input bit [7:0] w, input bit rdy);
    for (int i = 0; i < 8; i++) send_bit(w[i], rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    bit [7:0] w;
    m_words = 0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_sel", sel, 32'd0);
    check("rst_dout", dout, 32'h00);
    check("rst_valid", dout_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_overrun", overrun, 32'd0);

    // din_valid ignored in IDLE
    send_bit(1'b1, 1'b1);
    check("idle_ignore_sel", sel, 32'd0);

    // Mux bench pattern
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    w = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b1);
      check("pattern_sel", sel, 32'((i + 1) % 8));
    end
    check("pattern_dout", dout, 32'hAA);
    check("pattern_valid", dout_valid, 32'd1);
    idle(1'b1);
    check("pattern_consumed", dout_valid, 32'd0);

    // Gapped input
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b1);
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          idle(1'b1);
          check("gap_sel", sel, 32'd4);
        end
      end
    end
    check("gap_dout", dout, 32'hAA);
    check("gap_valid", dout_valid, 32'd1);
    idle(1'b1);

    // Backpressure and overrun
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hAA, 1'b0);
    send_word(8'h55, 1'b0);
    check("ovr_pulse", overrun, 32'd1);
    check("ovr_dout", dout, 32'hAA);
    check("ovr_valid", dout_valid, 32'd1);
    check("ovr_sel", sel, 32'd0);
    idle(1'b0);
    check("ovr_single", overrun, 32'd0);
    idle(1'b1);
    check("ovr_drain", dout_valid, 32'd0);

    // Same-edge transfer and completion
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hAA, 1'b0);
    w = 8'h0F;
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
    send_bit(w[7], 1'b1);
    check("same_edge_dout", dout, 32'h0F);
    check("same_edge_valid", dout_valid, 32'd1);
    check("same_edge_ovr", overrun, 32'd0);
    idle(1'b1);

    // Realign mid-word
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("realign_sel", sel, 32'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
    check("realign_dout", dout, 32'hFE);
    check("realign_valid", dout_valid, 32'd1);

    // Reset mid-word
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_sel", sel, 32'd0);
    check("midrst_valid", dout_valid, 32'd0);
    check("midrst_busy", busy, 32'd0);
    send_bit(1'b1, 1'b1);
    check("midrst_ignore_sel", sel, 32'd0);
    check("midrst_ignore_busy", busy, 32'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
